// File: rtl/cs_fuser_multi.sv
// Merges the first N per-byte /CS segments from the HPS SPI master into one
// continuous /CS per frame, with stall timeout, guard time and collision flags.
module cs_fuser_multi #(
  parameter int NUM_CS      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_LEN = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GUARD_CYC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CS-1:0] cs_in_n,
  output logic [NUM_CS-1:0] cs_out_n,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              proto_err
);

  localparam int CH_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GC_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GUARD_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GUARD} state_t;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
    return (l == '0) ? CNT_W'(1) : l;
  endfunction

  logic [NUM_CS-1:0] r_s1_p0, r_s2_p1, r_sd_p2;
  logic [NUM_CS-1:0] w_fall, w_rise, w_fall_low, w_ch_mask;
  logic              w_any_fall, w_extra_fall, w_other_fall;
  logic              w_s2_ch, w_fall_ch, w_rise_ch;
  logic [CH_W-1:0]   w_low_ch;

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [CNT_W-1:0]  r_len, w_len_nxt;
  logic [CNT_W-1:0]  r_seg, w_seg_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [GC_W-1:0]   r_gcnt, w_gcnt_nxt;
  logic [NUM_CS-1:0] r_cs_out_n, w_cs_nxt;
  logic              r_fd, w_fd_nxt;
  logic              r_to, w_to_nxt;
  logic              r_pe, w_pe_nxt;

  // Stage p0..p2: two-flop synchroniser plus delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_p0 <= '1;
      r_s2_p1 <= '1;
      r_sd_p2 <= '1;
    end else begin
      r_s1_p0 <= cs_in_n;
      r_s2_p1 <= r_s1_p0;
      r_sd_p2 <= r_s2_p1;
    end
  end

  assign w_fall       = r_sd_p2 & ~r_s2_p1;
  assign w_rise       = ~r_sd_p2 & r_s2_p1;
  assign w_any_fall   = |w_fall;
  assign w_fall_low   = w_fall & (~w_fall + NUM_CS'(1));
  assign w_extra_fall = |(w_fall & ~w_fall_low);
  assign w_ch_mask    = NUM_CS'(1) << r_ch;
  assign w_other_fall = |(w_fall & ~w_ch_mask);
  assign w_s2_ch      = |(r_s2_p1 & w_ch_mask);
  assign w_fall_ch    = |(w_fall & w_ch_mask);
  assign w_rise_ch    = |(w_rise & w_ch_mask);

  always_comb begin
    w_low_ch = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (w_fall[i]) w_low_ch = CH_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_len_nxt   = r_len;
    w_seg_nxt   = r_seg;
    w_tmr_nxt   = r_tmr;
    w_gcnt_nxt  = r_gcnt;
    w_cs_nxt    = r_cs_out_n;
    w_fd_nxt    = 1'b0;
    w_to_nxt    = 1'b0;
    w_pe_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cs_nxt = '1;
        // len_reg is only consulted in ACTIVE, so a same-cycle load applies to this frame
        if (cfg_valid) w_len_nxt = clamp_len(cfg_len);
        if (w_any_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_ch_nxt    = w_low_ch;
          w_cs_nxt    = ~w_fall_low;
          w_seg_nxt   = '0;
          w_tmr_nxt   = '0;
          w_pe_nxt    = w_extra_fall;
        end
      end
      ST_ACTIVE: begin
        w_pe_nxt = w_other_fall;
        if (w_rise_ch && (r_seg == r_len - CNT_W'(1))) begin
          w_cs_nxt    = '1;
          w_fd_nxt    = 1'b1;
          w_gcnt_nxt  = '0;
          w_state_nxt = ST_GUARD;
        end else if (w_s2_ch && (r_tmr == TMR_LAST)) begin
          w_cs_nxt    = '1;
          w_to_nxt    = 1'b1;
          w_gcnt_nxt  = '0;
          w_state_nxt = ST_GUARD;
        end else begin
          if (w_rise_ch) w_seg_nxt = r_seg + CNT_W'(1);
          if (w_fall_ch)    w_tmr_nxt = '0;
          else if (w_s2_ch) w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_GUARD: begin
        w_cs_nxt = '1;
        w_pe_nxt = w_any_fall;
        if (r_gcnt == GC_LAST) w_state_nxt = ST_IDLE;
        else                   w_gcnt_nxt  = r_gcnt + GC_W'(1);
      end
      default: begin
        w_cs_nxt    = '1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_len      <= CNT_W'(DEFAULT_LEN);
      r_seg      <= '0;
      r_tmr      <= '0;
      r_gcnt     <= '0;
      r_cs_out_n <= '1;
      r_fd       <= 1'b0;
      r_to       <= 1'b0;
      r_pe       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_len      <= w_len_nxt;
      r_seg      <= w_seg_nxt;
      r_tmr      <= w_tmr_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_cs_out_n <= w_cs_nxt;
      r_fd       <= w_fd_nxt;
      r_to       <= w_to_nxt;
      r_pe       <= w_pe_nxt;
    end
  end

  assign cs_out_n    = r_cs_out_n;
  assign cfg_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = r_fd;
  assign timeout_err = r_to;
  assign proto_err   = r_pe;

endmodule

// File: doc/cs_fuser_multi.md
# cs_fuser_multi

Parametrised multi-channel chip-select fuser between the HPS SPI master and one or more AT86RF215-class SPI slaves. The HPS drops /CS after every byte; this block merges the first N per-byte /CS segments of a transaction into one continuous /CS towards the selected slave. N is programmable per frame. A stall timeout and a minimum /CS-high guard time are enforced. Collisions between channels are flagged.

## Interface
Parameters:
- NUM_CS, 2: number of /CS channels, in and out, ≥1.
- CNT_W, 8: width of length register and segment counter.
- DEFAULT_LEN, 3: frame length in bytes loaded at reset, 1..2^CNT_W-1.
- TIMEOUT_CYC, 1024: clk cycles with master /CS high inside a frame before forced release, ≥1.
- GUARD_CYC, 4: clk cycles all outputs stay high after any release, ≥1.

Ports:
- clk  in  1  system clock, ≥4× SCLK.
- reset  in  1  synchronous, active-high reset.
- cs_in_n  in  NUM_CS  /CS from HPS, asynchronous to clk.
- cs_out_n  out  NUM_CS  fused /CS to slaves; at most one bit low.
- cfg_len  in  CNT_W  frame length in bytes for following frames; 0 is treated as 1.
- cfg_valid  in  1  cfg_len valid.
- cfg_ready  out  1  high only in IDLE; a transfer happens when cfg_valid & cfg_ready.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  1-cycle pulse on normal release.
- timeout_err  out  1  1-cycle pulse on timeout release.
- proto_err  out  1  1-cycle pulse on an ignored falling edge (collision or during GUARD).

## Operation
- Per-channel 2-FF synchroniser (s1, s2) plus delayed copy sd; all reset to 1. fall[i] = sd & ~s2; rise[i] = ~sd & s2.
- Registers: len_reg (reset DEFAULT_LEN), ch_reg ($clog2(NUM_CS) bits, reset 0), seg_cnt (CNT_W, reset 0), tmr (covers TIMEOUT_CYC), gcnt (covers GUARD_CYC).
- States: IDLE, ACTIVE, GUARD. Reset → IDLE.
- IDLE:
  - A config handshake loads len_reg ← max(cfg_len,1).
  - On any fall: ch_reg ← lowest-index falling channel; cs_out_n[ch] ← 0; seg_cnt ← 0; tmr ← 0; go to ACTIVE.
  - Other simultaneous falls pulse proto_err.
  - If a handshake and a fall occur in the same cycle, the new len_reg applies to this frame.
- ACTIVE:
  - rise[ch]: if seg_cnt == len_reg-1, set cs_out_n[ch] ← 1, pulse frame_done, gcnt ← 0, go to GUARD. Otherwise seg_cnt++.
  - tmr: counts while s2[ch] = 1; clears on fall[ch]. When tmr reaches TIMEOUT_CYC-1 with s2[ch] still high, release, pulse timeout_err, go to GUARD.
  - fall on any channel other than ch pulses proto_err and is otherwise ignored.
- GUARD:
  - All cs_out_n high. gcnt counts to GUARD_CYC-1, then go to IDLE.
  - Any fall during GUARD pulses proto_err and is ignored. A channel already low on IDLE entry does not start a frame; a fresh falling edge is required.
- cfg_ready = (state == IDLE). cfg_valid outside IDLE is held off and is not lost.
- Reset at any point: all outputs return to reset values on the next edge, and the frame is abandoned.

## Timing
- Reset values: cs_out_n all 1; cfg_ready 1; busy, frame_done, timeout_err, proto_err all 0.
- Assertion latency: cs_out_n[ch] goes low at the 3rd rising clk edge after the first edge sampling cs_in_n[ch] low (2 sync + 1 register).
- Release latency: 3 edges after the final master rising edge is sampled. frame_done is asserted in the same cycle that cs_out_n rises.
- Timeout: release occurs TIMEOUT_CYC cycles after rise[ch] is detected, if no fall[ch] occurs in between.
- Minimum cs_out_n high time between frames: GUARD_CYC+1 cycles.
- Segment count wraps only via release; seg_cnt never exceeds len_reg-1.
- Input pulses shorter than 2 clk may be missed; this is required behaviour, not an error.

## Test plan
- Reset → all outputs at reset values. Default 3-byte frame on ch0 (three low segments, gaps 10 clk) → cs_out_n[0] low from fall+3 to 3rd rise+3, one frame_done pulse, cs_out_n[1] stays 1.
- Handshake cfg_len=5 in IDLE, then 6 segments on ch1 → release after 5th rise. The 6th fall lands in GUARD (gap < GUARD_CYC) and pulses proto_err, or starts a new frame if the gap is larger. Also cfg_len=0 → 1-byte frames.
- Frame on ch0, master stops after 1 segment, TIMEOUT_CYC=32 → cs_out_n[0] rises 32 cycles after rise detection, timeout_err=1 once, frame_done never.
- Simultaneous falls ch0 & ch1 in IDLE → ch0 framed, proto_err pulse; ch1 fall mid-frame → second proto_err, cs_out_n[1] stays 1.
- cfg_valid asserted during ACTIVE → cfg_ready 0, load occurs in the first IDLE cycle. Reset asserted mid-frame after 1 segment → next edge cs_out_n=all 1, busy=0, len_reg=DEFAULT_LEN.
